// File: rtl/ram_pkg.sv
// Shared widths and wr_rd encoding for the single-port RAM.
package ram_pkg;

    localparam int unsigned RAM_ADDR_W = 8;
    localparam int unsigned RAM_DATA_W = 4;

    localparam logic WR_RD_WRITE = 1'b1;
    localparam logic WR_RD_READ  = 1'b0;

endpackage : ram_pkg

// File: rtl/spram_array.sv
// Storage array with a synchronous write port and an asynchronous read tap.
module spram_array
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c
);

    // No reset on the array so it maps onto block RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule : spram_array

// File: rtl/single_port_ram.sv
// Single-port RAM with a registered, synchronously reset read-data output.
module single_port_ram
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              wr_rd,
    input  logic              en
);

    logic              w_in_range;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata_c;
    logic [DATA_W-1:0] r_data_out;

    // Out-of-range addresses only exist when DEPTH < 2**ADDR_W.
    assign w_in_range = (32'(addr) < DEPTH);

    // An unknown wr_rd evaluates false here, so it can never write.
    assign w_we = rst & en & (wr_rd == WR_RD_WRITE) & w_in_range;

    spram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_addr    (addr),
        .i_wdata   (data_in),
        .o_rdata_c (w_rdata_c)
    );

    // Reset wins over any access; a non-write (including X on wr_rd) reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (en) begin
            if (wr_rd == WR_RD_WRITE) begin
                r_data_out <= r_data_out;
            end else begin
                r_data_out <= w_in_range ? w_rdata_c : '0;
            end
        end
    end

    assign data_out = r_data_out;

endmodule : single_port_ram

// File: tb/tb_single_port_ram.sv
// Directed self-checking bench for single_port_ram.
module tb_single_port_ram;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       wr_rd;
    logic       en;

    int checks   = 0;
    int failures = 0;

    single_port_ram dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .wr_rd    (wr_rd),
        .en       (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic cyc(input logic r, input logic e, input logic w,
                       input logic [7:0] a, input logic [3:0] d);
        rst = r; en = e; wr_rd = w; addr = a; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
            checks++;
            if (data_out !== 4'h0) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, data_out, 4'h0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'h33, 4'h9);
            checks++;
            if (data_out !== 4'h0) begin
                failures++;
                $display("FAIL reset_idle[%0d] got=%h exp=%h", i, data_out, 4'h0);
            end
        end
    endtask

    task automatic test_write_read();
        cyc(1'b1, 1'b1, 1'b1, 8'hAB, 4'h1);
        checks++;
        if (data_out !== 4'h0) begin
            failures++;
            $display("FAIL wr_no_through_ab got=%h exp=%h", data_out, 4'h0);
        end
        cyc(1'b1, 1'b1, 1'b1, 8'hBA, 4'h2);
        checks++;
        if (data_out !== 4'h0) begin
            failures++;
            $display("FAIL wr_no_through_ba got=%h exp=%h", data_out, 4'h0);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'hBA, 4'h0);
        checks++;
        if (data_out !== 4'h2) begin
            failures++;
            $display("FAIL rd_ba got=%h exp=%h", data_out, 4'h2);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'hAB, 4'h0);
        checks++;
        if (data_out !== 4'h1) begin
            failures++;
            $display("FAIL rd_ab got=%h exp=%h", data_out, 4'h1);
        end
    endtask

    task automatic test_reset_priority();
        cyc(1'b1, 1'b1, 1'b1, 8'h10, 4'h6);
        cyc(1'b1, 1'b1, 1'b0, 8'h10, 4'h0);
        checks++;
        if (data_out !== 4'h6) begin
            failures++;
            $display("FAIL rstpri_pre got=%h exp=%h", data_out, 4'h6);
        end
        cyc(1'b0, 1'b1, 1'b1, 8'h10, 4'hF);
        checks++;
        if (data_out !== 4'h0) begin
            failures++;
            $display("FAIL rstpri_during got=%h exp=%h", data_out, 4'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h10, 4'h0);
        checks++;
        if (data_out !== 4'h0) begin
            failures++;
            $display("FAIL rstpri_read_ignored got=%h exp=%h", data_out, 4'h0);
        end
        // First access right after release must work without a wait.
        cyc(1'b1, 1'b1, 1'b0, 8'h10, 4'h0);
        checks++;
        if (data_out !== 4'h6) begin
            failures++;
            $display("FAIL rstpri_after got=%h exp=%h", data_out, 4'h6);
        end
    endtask

    task automatic test_enable();
        cyc(1'b1, 1'b1, 1'b1, 8'h20, 4'h3);
        cyc(1'b1, 1'b1, 1'b0, 8'h20, 4'h0);
        checks++;
        if (data_out !== 4'h3) begin
            failures++;
            $display("FAIL en_setup got=%h exp=%h", data_out, 4'h3);
        end
        cyc(1'b1, 1'b0, 1'b1, 8'h20, 4'h7);
        checks++;
        if (data_out !== 4'h3) begin
            failures++;
            $display("FAIL en_off_write_out got=%h exp=%h", data_out, 4'h3);
        end
        cyc(1'b1, 1'b0, 1'b0, 8'hAB, 4'h0);
        checks++;
        if (data_out !== 4'h3) begin
            failures++;
            $display("FAIL en_off_read_out got=%h exp=%h", data_out, 4'h3);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'hAB, 4'h0);
        cyc(1'b1, 1'b1, 1'b0, 8'h20, 4'h0);
        checks++;
        if (data_out !== 4'h3) begin
            failures++;
            $display("FAIL en_off_mem got=%h exp=%h", data_out, 4'h3);
        end
    endtask

    task automatic test_boundaries();
        cyc(1'b1, 1'b1, 1'b0, 8'hBA, 4'h0);
        cyc(1'b1, 1'b1, 1'b1, 8'h00, 4'hA);
        checks++;
        if (data_out !== 4'h2) begin
            failures++;
            $display("FAIL bnd_wr00_out got=%h exp=%h", data_out, 4'h2);
        end
        cyc(1'b1, 1'b1, 1'b1, 8'hFF, 4'h5);
        cyc(1'b1, 1'b1, 1'b1, 8'hFF, 4'hC);
        checks++;
        if (data_out !== 4'h2) begin
            failures++;
            $display("FAIL bnd_wrff_out got=%h exp=%h", data_out, 4'h2);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 4'h0);
        checks++;
        if (data_out !== 4'hA) begin
            failures++;
            $display("FAIL bnd_rd00 got=%h exp=%h", data_out, 4'hA);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'hFF, 4'h0);
        checks++;
        if (data_out !== 4'hC) begin
            failures++;
            $display("FAIL bnd_rdff got=%h exp=%h", data_out, 4'hC);
        end
    endtask

    task automatic test_x_wr_rd();
        cyc(1'b1, 1'b1, 1'bx, 8'hAB, 4'hE);
        checks++;
        if (data_out !== 4'h1) begin
            failures++;
            $display("FAIL x_is_read got=%h exp=%h", data_out, 4'h1);
        end
        cyc(1'b1, 1'b1, 1'b0, 8'hBA, 4'h0);
        cyc(1'b1, 1'b1, 1'b0, 8'hAB, 4'h0);
        checks++;
        if (data_out !== 4'h1) begin
            failures++;
            $display("FAIL x_no_write got=%h exp=%h", data_out, 4'h1);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        prev = data_out;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] v;
            v = 4'(4'h9 + 4'(i * 3));
            cyc(1'b1, 1'b1, 1'b1, 8'h55, v);
            checks++;
            if (data_out !== prev) begin
                failures++;
                $display("FAIL b2b_wr[%0d] got=%h exp=%h", i, data_out, prev);
            end
            cyc(1'b1, 1'b1, 1'b0, 8'h55, 4'h0);
            checks++;
            if (data_out !== v) begin
                failures++;
                $display("FAIL b2b_rd[%0d] got=%h exp=%h", i, data_out, v);
            end
            prev = v;
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; wr_rd = 1'b0; addr = '0; data_in = '0;
        test_reset();
        test_write_read();
        test_reset_priority();
        test_enable();
        test_boundaries();
        test_x_wr_rd();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_single_port_ram

// File: doc/single_port_ram.md
SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-002 Parameter DATA_W, default 4, SHALL set the data width.
REQ-003 Parameter DEPTH, default 2**ADDR_W (256), SHALL set the number of words.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the reset: synchronous, active-low.
REQ-006 Port addr, input, ADDR_W, SHALL be the word address for reads and writes.
REQ-007 Port data_in, input, DATA_W, SHALL be the write data.
REQ-008 Port data_out, output, DATA_W, SHALL be the registered read data.
REQ-009 Port wr_rd, input, 1, SHALL select the operation: 1 = write, 0 = read.
REQ-010 Port en, input, 1, SHALL be the active-high access enable.
REQ-011 Port order SHALL be: clk, rst, addr, data_in, data_out, wr_rd, en.

Function
REQ-012 Storage SHALL be a DEPTH x DATA_W array with a single shared address port.
REQ-013 Write: rst=1, en=1, wr_rd=1 at an edge SHALL store data_in at mem[addr] at that edge.
REQ-014 data_out SHALL hold its previous value during a write; there is no write-through.
REQ-015 Read: rst=1, en=1, wr_rd=0 at an edge SHALL load mem[addr] into data_out at that edge, giving 1-cycle latency.
REQ-016 With en=0, neither memory nor data_out SHALL change, regardless of wr_rd, addr or data_in.
REQ-017 A read of an address written at an earlier edge SHALL return the newest written value.
REQ-018 Addresses >= DEPTH (only possible when DEPTH < 2**ADDR_W) SHALL make writes no-ops and reads return 0.
REQ-019 X/Z on wr_rd while en=1 SHALL be treated as a read.
REQ-020 Memory contents SHALL be undefined after power-up until written.

Reset
REQ-021 rst=0 at an edge SHALL force data_out to 0 at that edge.
REQ-022 Reset SHALL take priority over en, so a write or read in the same cycle as reset is ignored.
REQ-023 Reset SHALL NOT clear memory contents, keeping the array inferable as block RAM.
REQ-024 The first access after reset release SHALL behave normally, with no extra wait cycles.

Structure
REQ-025 ADDR_W/DATA_W defaults and the WRITE=1 / READ=0 encoding of wr_rd SHALL live in a shared package, ram_pkg.
REQ-026 One optional sub-module, spram_array (array plus write port), MAY hold storage; the output register and reset logic SHALL stay in single_port_ram.
REQ-027 The design SHALL be fully synchronous, with no latches and no combinational path from inputs to data_out.

Verification
REQ-028 Reset then idle: rst=0 for 2 cycles with en=0 -> data_out=0; rst=1, en=0 -> data_out stays 0.
REQ-029 Write/read-back: write 4'h1 @8'hAB, 4'h2 @8'hBA; read 8'hBA then 8'hAB -> data_out=4'h2 then 4'h1, each one edge after its read.
REQ-030 Reset priority: rst=0, en=1, wr_rd=1, data_in=4'hF @8'h10 -> after release, read @8'h10 returns its previous content (not 4'hF); data_out=0 during reset.
REQ-031 Enable gating: en=0, wr_rd=1, data_in=4'h7 @8'h20 after writing 4'h3 there -> read returns 4'h3; en=0 read leaves data_out unchanged.
REQ-032 Boundaries and overwrite: write 4'hA @8'h00 and 4'h5 @8'hFF, overwrite 8'hFF with 4'hC -> reads return 4'hA and 4'hC; data_out unchanged in write cycles.
REQ-033 Back-to-back: alternating write/read on consecutive cycles to one address -> every read returns the value from the preceding write.
